// File: rtl/arc4_ctrl.sv
// arc4_ctrl: top-level sequencer and s_mem arbiter for the ARC4 pipeline.
//
// One start handshake runs the three stages in order (init -> ksa -> prga).
// Each stage receives a one-cycle start pulse only once it reports ready,
// and the controller then waits for that stage to report completion.
// The shared 256x8 s_mem write/read port is granted to the active stage
// alone, and only while that stage is launched (GO) or running (BUSY).
//
// Optional feature: define ARC4_CTRL_WATCHDOG_EN to add a per-state cycle
// watchdog. It aborts to the ERR state when the controller spends TIMEOUT
// consecutive cycles in one WAIT or BUSY state. Without the macro, `err`
// stays 0, ERR is unreachable and TIMEOUT has no effect.
module arc4_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,

  // start handshake and status
  input  logic          en,
  output logic          rdy,
  output logic          done,
  output logic          err,
  output logic [1:0]    stage,

  // stage start pulses
  output logic          init_en,
  output logic          ksa_en,
  output logic          prga_en,

  // stage ready / complete
  input  logic          init_rdy,
  input  logic          ksa_rdy,
  input  logic          prga_rdy,

  // stage memory requests
  input  logic [AW-1:0] init_addr,
  input  logic [AW-1:0] ksa_addr,
  input  logic [AW-1:0] prga_addr,
  input  logic [DW-1:0] init_wrdata,
  input  logic [DW-1:0] ksa_wrdata,
  input  logic [DW-1:0] prga_wrdata,
  input  logic          init_wren,
  input  logic          ksa_wren,
  input  logic          prga_wren,

  // shared s_mem port
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wrdata,
  output logic          mem_wren
);

  // A watchdog that expires after zero cycles has no meaning.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("arc4_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] STAGE_INIT = 2'd0;
  localparam logic [1:0] STAGE_KSA  = 2'd1;
  localparam logic [1:0] STAGE_PRGA = 2'd2;

  state_t     state;
  logic [1:0] stage_q;
  logic       done_q;
  logic       err_q;
  logic       sel_rdy;
  logic       grant;
  logic       wd_expired;

  // Ready/complete flag of the currently selected stage.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_rdy = 1'b0;
    case (stage_q)
      STAGE_INIT: sel_rdy = init_rdy;
      STAGE_KSA:  sel_rdy = ksa_rdy;
      STAGE_PRGA: sel_rdy = prga_rdy;
      default:    sel_rdy = 1'b0;
    endcase
  end

`ifdef ARC4_CTRL_WATCHDOG_EN
  // Counter just wide enough to hold TIMEOUT; it never passes TIMEOUT-1
  // because reaching that value forces the state to change.
  localparam int            CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wd_cnt;
  logic          in_watch;
  logic          leaving;

  assign in_watch   = (state == S_WAIT) || (state == S_BUSY);
  assign wd_expired = in_watch && (wd_cnt == WD_LAST);

  // Flags the edge at which the current state is left, so the counter
  // starts from zero in whichever state is entered next.
  always_comb begin
    leaving = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: leaving = en;
      S_WAIT, S_BUSY:        leaving = sel_rdy | wd_expired;
      S_GO:                  leaving = 1'b1;
      default:               leaving = 1'b1;
    endcase
  end

  // Consecutive-cycle counter for the current WAIT or BUSY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (leaving) begin
      wd_cnt <= '0;
    end else if (in_watch) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Sequencer: walks the stages in order and records completion or abort.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stage_q <= STAGE_INIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state   <= S_WAIT;
            stage_q <= STAGE_INIT;
          end
        end

        S_WAIT: begin
          if (sel_rdy) begin
            state <= S_GO;
          end else if (wd_expired) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end
        end

        S_GO: begin
          state <= S_BUSY;
        end

        S_BUSY: begin
          if (sel_rdy) begin
            if (stage_q == STAGE_PRGA) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state   <= S_WAIT;
              stage_q <= stage_q + 2'd1;
            end
          end else if (wd_expired) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          // stage keeps its last value here until the next start
          if (en) begin
            state   <= S_WAIT;
            stage_q <= STAGE_INIT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and start pulses decoded straight from the state register.
  assign rdy     = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign done    = done_q;
  assign err     = err_q;
  assign stage   = stage_q;
  assign init_en = (state == S_GO) && (stage_q == STAGE_INIT);
  assign ksa_en  = (state == S_GO) && (stage_q == STAGE_KSA);
  assign prga_en = (state == S_GO) && (stage_q == STAGE_PRGA);

  // The port belongs to the selected stage only while it is launched or
  // running; a reset drops the grant at once because it clears the state.
  assign grant = (state == S_GO) || (state == S_BUSY);

  // Zero-latency arbiter: selected stage's request, or an idle port.
  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_wren   = 1'b0;
    if (grant) begin
      case (stage_q)
        STAGE_INIT: begin
          mem_addr   = init_addr;
          mem_wrdata = init_wrdata;
          mem_wren   = init_wren;
        end
        STAGE_KSA: begin
          mem_addr   = ksa_addr;
          mem_wrdata = ksa_wrdata;
          mem_wren   = ksa_wren;
        end
        STAGE_PRGA: begin
          mem_addr   = prga_addr;
          mem_wrdata = prga_wrdata;
          mem_wren   = prga_wren;
        end
        default: begin
          mem_addr   = '0;
          mem_wrdata = '0;
          mem_wren   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: self-checking bench for arc4_ctrl.
// Stage behaviour is emulated by small drivers with a configurable busy
// length; a sequence-level reference model predicts every output each
// cycle, and directed runs pin absolute latencies and pulse positions.
// Build with ARC4_CTRL_WATCHDOG_EN to exercise the watchdog abort path.
`timescale 1ns/1ps
module tb_arc4_ctrl;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;
`ifdef ARC4_CTRL_WATCHDOG_EN
  localparam int B_INIT = 6;
  localparam int B_KSA  = 12;
  localparam int B_PRGA = 4;
`else
  localparam int B_INIT = 256;
  localparam int B_KSA  = 768;
  localparam int B_PRGA = 64;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rdy, done, err;
  logic [1:0]    stage;
  logic          init_en, ksa_en, prga_en;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrdata;

  logic          s_rdy    [3];
  logic [AW-1:0] s_addr   [3];
  logic [DW-1:0] s_wrdata [3];
  logic          s_wren   [3];
  wire  [2:0]    s_en = {prga_en, ksa_en, init_en};

  arc4_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .en(en), .rdy(rdy), .done(done), .err(err), .stage(stage),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(s_rdy[0]), .ksa_rdy(s_rdy[1]), .prga_rdy(s_rdy[2]),
    .init_addr(s_addr[0]), .ksa_addr(s_addr[1]), .prga_addr(s_addr[2]),
    .init_wrdata(s_wrdata[0]), .ksa_wrdata(s_wrdata[1]), .prga_wrdata(s_wrdata[2]),
    .init_wren(s_wren[0]), .ksa_wren(s_wren[1]), .prga_wren(s_wren[2]),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // ---------------- stage emulation ----------------
  int b_len [3];
  bit rand_idle;
  bit pat;
  int hold_stage;
  bit hold_started;
  int hold_left;
  bit s_active [3];
  int s_k [3];

  // Each stage: after its start pulse, ready stays low until busy cycle B.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        s_active[k] = 1'b0;
        s_k[k]      = 0;
        s_rdy[k]    = 1'b1;
      end
      hold_left = 0;
    end else begin
      if (hold_stage >= 0 && !hold_started && !rdy && stage == 2'(hold_stage)) begin
        hold_left    = 5;
        hold_started = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (s_active[k]) begin
          s_k[k]++;
          if (s_k[k] >= b_len[k]) begin
            s_rdy[k]    = 1'b1;
            s_active[k] = 1'b0;
          end else begin
            s_rdy[k] = 1'b0;
          end
        end else if (s_en[k]) begin
          s_k[k]      = 0;
          s_active[k] = (b_len[k] > 1);
          s_rdy[k]    = (b_len[k] <= 1);
        end else if (k == hold_stage && hold_left > 0) begin
          s_rdy[k] = 1'b0;
          hold_left--;
        end else begin
          s_rdy[k] = rand_idle ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      s_addr[k]   = AW'($urandom);
      s_wrdata[k] = DW'($urandom);
      s_wren[k]   = $urandom_range(0, 1) == 1;
    end
    if (pat) begin
      s_addr[0] = 8'hAA;
      s_wren[0] = 1'b1;
      s_addr[1] = 8'h3C; s_wrdata[1] = 8'h5A; s_wren[1] = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Sequence-level view: is a run active, which stage, has it been
  // launched yet, is this the launch cycle, how long in the current phase.
  bit m_run, m_go, m_launch, m_done, m_err;
  int m_stage, m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_go = 0; m_launch = 0; m_done = 0; m_err = 0;
      m_stage = 0; m_age = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_stage = 0; m_go = 0; m_launch = 0;
        m_done = 0; m_err = 0; m_age = 0;
      end
    end else if (m_go) begin
      m_go = 0; m_launch = 1; m_age = 0;
    end else if (s_rdy[m_stage]) begin
      m_age = 0;
      if (!m_launch) m_go = 1;
      else if (m_stage == 2) begin m_run = 0; m_launch = 0; m_done = 1; end
      else begin m_stage++; m_launch = 0; end
    end
`ifdef ARC4_CTRL_WATCHDOG_EN
    else if (m_age + 1 >= TIMEOUT) begin
      m_run = 0; m_launch = 0; m_err = 1; m_age = 0;
    end
`endif
    else begin
      m_age++;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [7:0]  exp_ctl;
    logic [16:0] exp_mem;
    bit          grant;
    exp_ctl = {!m_run, m_done, m_err, 2'(m_stage),
               m_go && m_stage == 0, m_go && m_stage == 1, m_go && m_stage == 2};
    grant   = m_run && (m_go || m_launch);
    exp_mem = grant ? {s_wren[m_stage], s_addr[m_stage], s_wrdata[m_stage]} : 17'd0;
    check("cyc_ctl", {rdy, done, err, stage, init_en, ksa_en, prga_en}, exp_ctl);
    check("cyc_mem", {mem_wren, mem_addr, mem_wrdata}, exp_mem);
  end

  // Start-pulse log for order and position checks.
  int pulse_cnt [3];
  int pulse_cyc [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (s_en[k]) begin pulse_cnt[k]++; pulse_cyc[k] = cyc; end
  end

  task automatic clear_pulses();
    for (int k = 0; k < 3; k++) begin pulse_cnt[k] = 0; pulse_cyc[k] = -1; end
  endtask

  // One full run from IDLE/DONE/ERR; hold adds prga WAIT delay cycles.
  task automatic run_once(input string tag, input int hold);
    int e0, t_done;
    bit seen;
    clear_pulses();
    en = 1'b1; tick(); en = 1'b0;
    e0 = cyc;
    check({tag, "_rdy_low"}, rdy, 1'b0);
    check({tag, "_done_clr"}, done, 1'b0);
    seen = 0; t_done = -1;
    for (int c = 0; c < 5000 && !seen; c++) begin
      if (cyc == e0 + b_len[0] + 5) pat = 1'b1;
      if (cyc == e0 + b_len[0] + 6) begin
        check({tag, "_ksa_mux"}, {mem_wren, mem_addr, mem_wrdata}, {1'b1, 8'h3C, 8'h5A});
        pat = 1'b0;
      end
      en = (cyc == e0 + b_len[0] + 7);
      tick();
      if (done) begin seen = 1; t_done = cyc; end
    end
    en = 1'b0;
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_done_lat"}, 32'(t_done - e0), 32'(6 + b_len[0] + b_len[1] + b_len[2] + hold));
    check({tag, "_init_cnt"}, pulse_cnt[0], 1);
    check({tag, "_ksa_cnt"},  pulse_cnt[1], 1);
    check({tag, "_prga_cnt"}, pulse_cnt[2], 1);
    check({tag, "_init_at"}, 32'(pulse_cyc[0] - e0), 32'd1);
    check({tag, "_ksa_at"},  32'(pulse_cyc[1] - e0), 32'(3 + b_len[0]));
    check({tag, "_prga_at"}, 32'(pulse_cyc[2] - e0), 32'(5 + b_len[0] + b_len[1] + hold));
    check({tag, "_end_st"}, {rdy, done, err, stage}, {3'b110, 2'd2});
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int e0, t_err;
    bit seen;
    en = 1'b0; pat = 1'b0; rand_idle = 1'b0;
    hold_stage = -1; hold_started = 1'b0; hold_left = 0;
    b_len = '{B_INIT, B_KSA, B_PRGA};
    for (int k = 0; k < 3; k++) begin
      s_rdy[k] = 1'b1; s_addr[k] = '0; s_wrdata[k] = '0; s_wren[k] = 1'b0;
      s_active[k] = 1'b0; s_k[k] = 0;
    end
    clear_pulses();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // reset state
    check("rst_status", {rdy, done, err, stage}, {3'b100, 2'd0});
    check("rst_en", s_en, 3'b000);
    check("rst_mem", {mem_wren, mem_addr, mem_wrdata}, 17'd0);

    // full run, then restart from DONE, then delayed prga ready
    run_once("run1", 0);
    run_once("run2", 0);
    hold_stage = 2; hold_started = 1'b0;
    run_once("hold", 5);
    hold_stage = -1;

    // asynchronous reset while ksa is busy and writing
    clear_pulses();
    en = 1'b1; tick(); en = 1'b0;
    e0 = cyc;
    for (int c = 0; c < 2000 && cyc != e0 + b_len[0] + 5; c++) tick();
    pat = 1'b1; tick();
    check("rst_pre_wren", mem_wren, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_wren", mem_wren, 1'b0);
    check("rst_async_st", {rdy, done, err, stage}, {3'b100, 2'd0});
    pat = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    clear_pulses();
    repeat (10) tick();
    check("rst_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
    check("rst_idle_rdy", rdy, 1'b1);

    // ksa never completes
    b_len[1] = 1000000;
    pat = 1'b1;
    en = 1'b1; tick(); en = 1'b0;
    e0 = cyc;
`ifdef ARC4_CTRL_WATCHDOG_EN
    seen = 0; t_err = -1;
    for (int c = 0; c < 2000 && !seen; c++) begin
      tick();
      if (err) begin seen = 1; t_err = cyc; end
    end
    check("wd_err_seen", seen, 1'b1);
    check("wd_err_at", 32'(t_err - e0), 32'(4 + b_len[0] + TIMEOUT));
    check("wd_err_st", {rdy, done, stage, mem_wren}, {2'b10, 2'd1, 1'b0});
    pat = 1'b0;
    b_len[1] = B_KSA;
    run_once("wd_restart", 0);
`else
    seen = 0; t_err = 0;
    repeat (4 + b_len[0] + TIMEOUT + 20) tick();
    check("nowd_stuck", {rdy, err, stage, mem_wren}, {2'b00, 2'd1, 1'b1});
    pat = 1'b0;
    b_len[1] = B_KSA;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`endif

    // randomized traffic against the model
    rand_idle = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      for (int k = 0; k < 3; k++) b_len[k] = $urandom_range(1, 6);
      for (int c = 0; c < 150; c++) begin
        en = ($urandom_range(0, 5) == 0);
        tick();
      end
    end
    en = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
